// File: rtl/uart_rx.sv
// Asynchronous serial receiver with mid-bit sampling and one-cycle result strobes.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int ClockFrequency = 24_000_000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [NrOfDataBits-1:0] dataBits,
    output logic                    dataValid,
    output logic                    frameError,
    output logic                    parityError,
    output logic                    busy
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int HalfBit      = ClocksPerBit / 2;
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int BitW         = $clog2(NrOfDataBits + 1);

    localparam logic [CntW-1:0] FullEnd = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(NrOfDataBits - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [NrOfDataBits-1:0] d);
        even_parity = ^d;
    endfunction
`endif

    logic                    r_sync1;
    logic                    r_rxS;
    state_t                  r_state;
    logic [CntW-1:0]         r_cnt;
    logic [BitW-1:0]         r_bit_cnt;
    logic [NrOfDataBits-1:0] r_shift;
    logic                    r_evt_valid;
    logic                    r_evt_frame;
`ifdef UART_RX_PARITY_EN
    logic                    r_par_ok;
    logic                    r_evt_par;
`endif

    // Two-flop synchronizer; reset to the idle line level so no false start appears.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rxS   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxS   <= r_sync1;
        end
    end

    // Frame recovery state machine; result events are re-registered by the output stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CntW{1'b0}};
            r_bit_cnt   <= {BitW{1'b0}};
            r_shift     <= {NrOfDataBits{1'b0}};
            r_evt_valid <= 1'b0;
            r_evt_frame <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_ok    <= 1'b1;
            r_evt_par   <= 1'b0;
`endif
        end else begin
            r_evt_valid <= 1'b0;
            r_evt_frame <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_evt_par   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= {CntW{1'b0}};
                    r_bit_cnt <= {BitW{1'b0}};
`ifdef UART_RX_PARITY_EN
                    r_par_ok  <= 1'b1;
`endif
                    if (!r_rxS) begin
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == HalfEnd) begin
                        r_cnt <= {CntW{1'b0}};
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (r_rxS) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FullEnd) begin
                        r_cnt     <= {CntW{1'b0}};
                        r_shift   <= {r_rxS, r_shift[NrOfDataBits-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LastBit) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == FullEnd) begin
                        r_cnt    <= {CntW{1'b0}};
                        r_par_ok <= (r_rxS == even_parity(r_shift));
                        r_state  <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == FullEnd) begin
                        r_cnt <= {CntW{1'b0}};
                        if (r_rxS) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_ok) begin
                                r_evt_valid <= 1'b1;
                            end else begin
                                r_evt_par <= 1'b1;
                            end
`else
                            r_evt_valid <= 1'b1;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            r_evt_frame <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (r_rxS) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_BREAK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs: strobes, status and the held data word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataBits    <= {NrOfDataBits{1'b0}};
            dataValid   <= 1'b0;
            frameError  <= 1'b0;
            parityError <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dataValid  <= r_evt_valid;
            frameError <= r_evt_frame;
`ifdef UART_RX_PARITY_EN
            parityError <= r_evt_par;
`else
            parityError <= 1'b0;
`endif
            busy <= (r_state != S_IDLE);
            if (r_evt_valid) begin
                dataBits <= r_shift;
            end else begin
                dataBits <= dataBits;
            end
        end
    end

endmodule
